// File: rtl/counter_dec_ctrl.sv
// Run controller for a cascaded BCD counter chain: load/start/stop, up/down stepping,
// terminal detection with one-shot or auto-reload. COUNTER_DEC_CTRL_PRESCALE_EN adds a tick prescaler.
module counter_dec_ctrl #(
    parameter int p_digits = 4,
    parameter int p_div    = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*p_digits-1:0] i_preset,
    input  logic [4*p_digits-1:0] i_limit,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_dir,
    input  logic                  i_mode,
    input  logic                  i_tick,
    output logic [4*p_digits-1:0] o_val,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_state
);
    // state  | meaning
    // IDLE   | loaded or reset, waiting for start
    // RUN    | stepping on ticks
    // HOLD   | stopped mid-run, value and prescale phase kept
    // DONE   | one-shot terminal reached, load required before restart

    localparam int W = 4 * p_digits;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    if (p_digits < 1 || p_digits > 8) begin : g_bad_digits
        $error("counter_dec_ctrl: p_digits out of range");
    end
    if (p_div < 2 || p_div > 1023) begin : g_bad_div
        $error("counter_dec_ctrl: p_div out of range");
    end

    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < p_digits; d++) begin
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < p_digits; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < p_digits; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t         state_q;
    logic [W-1:0]   val_q;
    logic [W-1:0]   preset_q;
    logic [W-1:0]   limit_q;
    logic           mode_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           preset_ok;
    logic           limit_ok;
    logic [W-1:0]   term;
    logic           at_term;
    logic [W-1:0]   val_step;
    logic           step;

    assign preset_ok = is_bcd(i_preset);
    assign limit_ok  = is_bcd(i_limit);
    assign term      = i_dir ? '0 : limit_q;
    assign at_term   = (val_q == term);
    assign val_step  = i_dir ? bcd_dec(val_q) : bcd_inc(val_q);

`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
    localparam int            PW         = $clog2(p_div);
    localparam logic [PW-1:0] PRE_RELOAD = PW'(p_div - 1);
    // Down-counter; a step issues on the tick that finds it at zero.
    logic [PW-1:0] pre_q;
    assign step = i_tick && (pre_q == '0);
`else
    assign step = i_tick;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            val_q    <= '0;
            preset_q <= '0;
            limit_q  <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
            pre_q    <= PRE_RELOAD;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (i_load && state_q != S_RUN) begin
                if (preset_ok) begin
                    val_q    <= i_preset;
                    preset_q <= i_preset;
                    if (state_q == S_DONE) state_q <= S_IDLE;
`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
                    pre_q    <= PRE_RELOAD;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end else if (i_stop && state_q == S_RUN) begin
                state_q <= S_HOLD;
                busy_q  <= 1'b0;
            end else if (i_start && (state_q == S_IDLE || state_q == S_HOLD)) begin
                if (limit_ok) begin
                    limit_q <= i_limit;
                    mode_q  <= i_mode;
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
                    // Resuming from HOLD keeps the partial prescale count.
                    if (state_q == S_IDLE) pre_q <= PRE_RELOAD;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end else if (state_q == S_RUN && i_tick) begin
`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
                pre_q <= (pre_q == '0) ? PRE_RELOAD : pre_q - PW'(1);
`endif
                if (step) begin
                    if (at_term) begin
                        done_q <= 1'b1;
                        if (mode_q) begin
                            val_q <= preset_q;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        val_q <= val_step;
                    end
                end
            end
        end
    end

    assign o_val   = val_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_counter_dec_ctrl.sv
// Scoreboard bench for counter_dec_ctrl: stimulus queues hand-computed expectations,
// a monitor pops one per cycle after each edge and compares.
module tb_counter_dec_ctrl;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic        st  = 1'b0;
    logic        sp  = 1'b0;
    logic        dir = 1'b0;
    logic        md  = 1'b0;
    logic        tk  = 1'b0;
    logic [15:0] pre = '0;
    logic [15:0] lim = '0;

    logic [15:0] o_val;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_state;

    always #5 clk = ~clk;

    counter_dec_ctrl #(.p_digits(4), .p_div(3)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_load   (ld),
        .i_preset (pre),
        .i_limit  (lim),
        .i_start  (st),
        .i_stop   (sp),
        .i_dir    (dir),
        .i_mode   (md),
        .i_tick   (tk),
        .o_val    (o_val),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_state  (o_state)
    );

    typedef struct {
        logic [15:0] val;
        logic [1:0]  state;
        logic        done;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            n_vec++;
            if (o_val !== mx.val || o_state !== mx.state || o_busy !== (mx.state == RUN) ||
                o_done !== mx.done || o_err !== mx.err) begin
                n_bad++;
                $display("FAIL %s: got val=%h state=%0d busy=%b done=%b err=%b, want val=%h state=%0d busy=%b done=%b err=%b",
                         mx.tag, o_val, o_state, o_busy, o_done, o_err,
                         mx.val, mx.state, (mx.state == RUN), mx.done, mx.err);
            end
        end
    end

    task automatic apply(input string tag, input logic [15:0] v, input logic [1:0] s,
                         input logic d, input logic e);
        exp_t x;
        x.val = v; x.state = s; x.done = d; x.err = e; x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; ld = 1'b0; st = 1'b0; sp = 1'b0; tk = 1'b0;
    endtask

    logic [15:0] s1_up[5];
    logic [15:0] s2_dn[5];
    logic [15:0] ps_v[9];

    initial begin
        s1_up = '{16'h0096, 16'h0097, 16'h0098, 16'h0099, 16'h0100};
        s2_dn = '{16'h0002, 16'h0001, 16'h0000, 16'h0003, 16'h0002};
        ps_v  = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                  16'h0002, 16'h0002, 16'h0002, 16'h0003};

        apply("reset", 16'h0000, IDLE, 1'b0, 1'b0);

`ifdef COUNTER_DEC_CTRL_PRESCALE_EN
        ld = 1; pre = 16'h0000;                 apply("ps_load", 16'h0000, IDLE, 0, 0);
        st = 1; lim = 16'h0099; dir = 0; md = 0; apply("ps_start", 16'h0000, RUN, 0, 0);
        for (int i = 0; i < 9; i++) begin
            tk = 1; apply("ps_tick", ps_v[i], RUN, 0, 0);
        end
        tk = 1; apply("ps_t1", 16'h0003, RUN, 0, 0);
        tk = 1; apply("ps_t2", 16'h0003, RUN, 0, 0);
        sp = 1;                                  apply("ps_stop", 16'h0003, HOLD, 0, 0);
        tk = 1;                                  apply("ps_hold_tick", 16'h0003, HOLD, 0, 0);
        st = 1;                                  apply("ps_resume", 16'h0003, RUN, 0, 0);
        tk = 1;                                  apply("ps_resume_tick", 16'h0004, RUN, 0, 0);
`else
        ld = 1; pre = 16'h0095;                  apply("s1_load", 16'h0095, IDLE, 0, 0);
        st = 1; lim = 16'h0100; dir = 0; md = 0; apply("s1_start", 16'h0095, RUN, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tk = 1; apply("s1_tick", s1_up[i], RUN, 0, 0);
        end
        tk = 1;                                  apply("s1_done", 16'h0100, DONE, 1, 0);
        apply("s1_after", 16'h0100, DONE, 0, 0);
        tk = 1;                                  apply("s1_done_tick", 16'h0100, DONE, 0, 0);
        st = 1;                                  apply("s1_done_start", 16'h0100, DONE, 0, 0);

        ld = 1; pre = 16'h0003;                  apply("s2_load", 16'h0003, IDLE, 0, 0);
        st = 1; lim = 16'h0000; dir = 1; md = 1; apply("s2_start", 16'h0003, RUN, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tk = 1; apply("s2_tick", s2_dn[i], RUN, (i == 3), 0);
        end
        sp = 1; tk = 1;                          apply("s2_stop_tick", 16'h0002, HOLD, 0, 0);
        tk = 1;                                  apply("s2_hold_tick", 16'h0002, HOLD, 0, 0);
        st = 1;                                  apply("s2_resume", 16'h0002, RUN, 0, 0);
        tk = 1;                                  apply("s2_resume_tick", 16'h0001, RUN, 0, 0);
        rst = 1; tk = 1;                         apply("s2_rst_run", 16'h0000, IDLE, 0, 0);

        ld = 1; pre = 16'h9999;                  apply("s3_load", 16'h9999, IDLE, 0, 0);
        st = 1; lim = 16'h0001; dir = 0; md = 0; apply("s3_start", 16'h9999, RUN, 0, 0);
        tk = 1;                                  apply("s3_wrap", 16'h0000, RUN, 0, 0);
        tk = 1;                                  apply("s3_step", 16'h0001, RUN, 0, 0);
        tk = 1;                                  apply("s3_done", 16'h0001, DONE, 1, 0);

        ld = 1; pre = 16'h00A5;                  apply("s4_bad_load", 16'h0001, DONE, 0, 1);
        apply("s4_err_clear", 16'h0001, DONE, 0, 0);
        ld = 1; pre = 16'h0000;                  apply("s4_load", 16'h0000, IDLE, 0, 0);
        st = 1; lim = 16'h1F00;                  apply("s4_bad_start", 16'h0000, IDLE, 0, 1);
        apply("s4_err_clear2", 16'h0000, IDLE, 0, 0);

        ld = 1; pre = 16'h0005;                  apply("s5_load", 16'h0005, IDLE, 0, 0);
        st = 1; lim = 16'h0009; dir = 0; md = 0; apply("s5_start", 16'h0005, RUN, 0, 0);
        tk = 1;                                  apply("s5_up", 16'h0006, RUN, 0, 0);
        tk = 1; dir = 1;                         apply("s5_down", 16'h0005, RUN, 0, 0);
        tk = 1; dir = 0;                         apply("s5_up2", 16'h0006, RUN, 0, 0);
        sp = 1;                                  apply("s5_stop", 16'h0006, HOLD, 0, 0);
        ld = 1; pre = 16'h0009;                  apply("s5_hold_load", 16'h0009, HOLD, 0, 0);
        st = 1; lim = 16'h0009;                  apply("s5_start_at_term", 16'h0009, RUN, 0, 0);
        tk = 1;                                  apply("s5_first_tick_done", 16'h0009, DONE, 1, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_dec_ctrl.md
Name: counter_dec_ctrl

Overview:
Run controller for a multi-digit decimal (BCD) counter chain built from cascaded decimal digits linked by carry/borrow. Sequences load, start, stop, up/down stepping and terminal-count detection, with one-shot or auto-reload modes. Sits between timing/control logic (tick source, host registers) and display or compare consumers of the BCD value.

Parameters:
p_digits, 4, number of BCD digits in the chain (1..8); value width is 4*p_digits
p_div, 10, tick prescale ratio (2..1023); used only with the optional feature

Ports:
i_clk     input   1            clock; all logic on rising edge
i_rst     input   1            synchronous reset, active-high
i_load    input   1            load i_preset into value and preset register (non-RUN states only)
i_preset  input   4*p_digits   BCD preset, nibble 0 = least significant digit
i_limit   input   4*p_digits   BCD up-count terminal, sampled on start
i_start   input   1            enter RUN
i_stop    input   1            leave RUN and enter HOLD
i_dir     input   1            0 = count up, 1 = count down; sampled on every tick
i_mode    input   1            0 = one-shot, 1 = auto-reload; sampled on start
i_tick    input   1            count strobe, one step per high cycle in RUN
o_val     output  4*p_digits   current BCD value, registered
o_busy    output  1            high while state is RUN
o_done    output  1            one-cycle pulse on terminal count
o_err     output  1            one-cycle pulse on rejected load or start (non-BCD nibble)
o_state   output  2            0 IDLE, 1 RUN, 2 HOLD, 3 DONE

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; value, preset register, limit register and mode register = 0; o_busy, o_done and o_err = 0. Reset overrides all other inputs in any state, including mid-RUN.
- Priority within a cycle: i_rst > i_load > i_stop > i_start > i_tick.
- Load, accepted in IDLE, HOLD or DONE:
  - Every i_preset nibble must be <= 9. If so, the value and preset register take i_preset on the next edge and DONE goes to IDLE.
  - If any nibble is > 9, o_err pulses for 1 cycle and the value, registers and state are unchanged.
  - Load in RUN is ignored, with no error.
- Start, accepted in IDLE or HOLD:
  - Every i_limit nibble must be <= 9. If so, the limit register takes i_limit, the mode register takes i_mode, and the state becomes RUN on the next edge.
  - An invalid limit pulses o_err, and the state is unchanged.
  - Start in DONE is ignored; a load is required first.
- Stop in RUN: the state becomes HOLD and a same-cycle tick is discarded. Stop in any other state is ignored.
- Tick in RUN, with terminal = limit register when i_dir=0 and terminal = 0 when i_dir=1:
  - If value != terminal: the value steps by 1 in decimal.
    - Up: a digit at 9 goes to 0 and carries.
    - Down: a digit at 0 goes to 9 and borrows.
    - The whole chain wraps: all-9 +1 gives 0; 0 -1 gives all-9. A wrap never raises o_done.
  - If value == terminal: o_done pulses for 1 cycle at the next edge.
    - One-shot: the value holds and the state becomes DONE.
    - Reload: the value takes the preset register and the state stays RUN.
- A terminal is therefore displayed for one full tick period before o_done. A start with value already at terminal produces o_done on the first tick.
- Latency: o_val changes 1 cycle after the sampled i_tick. o_done is coincident with the reload or the state change.
- Ticks in IDLE, HOLD or DONE are ignored. A change of i_dir takes effect on the next tick.
- Up counting with limit < value passes through the all-9 wrap before reaching the limit. This is legal behaviour.
- o_busy = (state == RUN). o_state is a registered encoding of the state.

Optional Feature:
- Macro: COUNTER_DEC_CTRL_PRESCALE_EN.
- Defined:
  - An internal prescaler counts i_tick pulses in RUN only and issues one step every p_div ticks.
  - The prescaler clears on reset, load, start and entry to DONE, and is held (not cleared) in HOLD.
  - The o_done timing rules apply to the prescaled step.
- Undefined: each i_tick is a step, p_div is unused, and no prescaler registers exist.

Test Plan:
- Reset, load 0x0095, limit 0x0100, up, one-shot, start, then 6 ticks -> o_val 0096..0100 after 5 ticks; o_done pulse on the 6th tick; o_state=3; o_val holds at 0x0100.
- Load 0x0003, down, reload, start, then 5 ticks -> o_val 0002, 0001, 0000; o_done on the 4th tick with o_val=0003; 5th tick gives 0002; o_busy stays 1.
- Load 0x9999, up, limit 0x0001, start, then 2 ticks -> o_val 0000, then 0001; no o_done on the wrap; o_done on the 3rd tick.
- Load 0x00A5 -> o_err pulses 1 cycle and o_val is unchanged. Start with limit 0x1F00 -> o_err pulses and the state stays IDLE.
- In RUN, assert i_stop and i_tick together -> state HOLD with o_val unchanged; ticks ignored; i_start resumes with a correct count; i_rst mid-RUN gives o_val=0 and IDLE next cycle.
- With COUNTER_DEC_CTRL_PRESCALE_EN and p_div=3, 9 ticks in RUN -> o_val advances by exactly 3; a stop after tick 2 then resume steps after 1 further tick.
